// File: rtl/nibble_serial_adder_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_if
// Bundles the operand/request and result/status signals of
// nibble_serial_adder.
//   master : drives start, in_data1, in_data2 (and sub); observes busy, done,
//            out_data, cy
//   slave  : the adder side (inverse directions)
// Optional macro NIBBLE_SERIAL_ADDER_SUB_EN adds the 'sub' request bit.
// -----------------------------------------------------------------------------
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] out_data;
  logic         cy;

  modport master (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, in_data1, in_data2,
    input  busy, done, out_data, cy
  );

  modport slave (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, in_data1, in_data2,
    output busy, done, out_data, cy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Wide adder built around the 4-bit adder4 block: operands are latched on an
// accepted start, then processed one nibble per clock (LSB nibble first) with
// the inter-nibble carry held in a register. The wide sum and final carry are
// published on the last nibble edge together with a one-cycle done pulse.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : nibble_serial_adder_if.slave
//            start/in_data1/in_data2[/sub] in, busy/done/out_data/cy out
// Parameter NIBBLES (2..16): operand width is 4*NIBBLES bits.
// Macro NIBBLE_SERIAL_ADDER_SUB_EN: adds bus.sub; sub=1 computes A + ~B + 1,
// and cy=1 then means no borrow.
// -----------------------------------------------------------------------------

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       cy
);
  assign {cy, s} = {1'b0, a} + {1'b0, b};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [CW-1:0]   cnt;
  logic            carry_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    res_reg;
  logic [W-1:0]    res_nx;
  logic [W-1:0]    out_reg;
  logic            cy_reg;
  logic            done_reg;
  logic            sub_reg;
  logic            init_carry;

  logic            accept;
  logic            last;
  logic            busy_c;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      s1;
  logic [3:0]      s2;
  logic            cy1;
  logic            cy2;
  logic            nib_cy;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign init_carry = bus.sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_reg <= 1'b0;
    end else if (accept) begin
      sub_reg <= bus.sub;
    end
  end
`else
  assign init_carry = 1'b0;
  assign sub_reg    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN:  if (cnt == CW'(NIBBLES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy_c = 1'b0;
    accept = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE: accept = bus.start;
      RUN: begin
        busy_c = 1'b1;
        last   = (cnt == CW'(NIBBLES - 1));
      end
      default: ;
    endcase
  end

  // Select the current nibble pair; subtraction inverts the B nibble.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
    if (sub_reg) b_nib = ~b_nib;
  end

  adder4 u_stage1 (
    .a  (a_nib),
    .b  (b_nib),
    .s  (s1),
    .cy (cy1)
  );

  adder4 u_stage2 (
    .a  (s1),
    .b  ({3'b000, carry_reg}),
    .s  (s2),
    .cy (cy2)
  );

  // The two stage carries are mutually exclusive, so OR is the true carry.
  assign nib_cy = cy1 | cy2;

  // Result with the current nibble merged in; also feeds out_data on the
  // final edge so the last nibble is included without an extra cycle.
  always_comb begin
    res_nx = res_reg;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) res_nx[4*i +: 4] = s2;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      out_reg   <= '0;
      cy_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= last;
      if (accept) begin
        a_reg     <= bus.in_data1;
        b_reg     <= bus.in_data2;
        cnt       <= '0;
        carry_reg <= init_carry;
      end else if (busy_c) begin
        res_reg   <= res_nx;
        carry_reg <= nib_cy;
        cnt       <= last ? '0 : cnt + CW'(1);
        if (last) begin
          out_reg <= res_nx;
          cy_reg  <= nib_cy;
        end
      end
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_reg;
  assign bus.out_data = out_reg;
  assign bus.cy       = cy_reg;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-nibble adder controller that sits directly upstream of the 4-bit `adder4` combinational adder. It latches two wide operands on a start strobe, sends them through `adder4` one nibble per clock from least to most significant, and propagates the carry in a register between nibbles. It assembles the wide sum and final carry, then reports completion with a one-cycle `done` pulse. This lets the 4-bit adder serve as the datapath for 16-bit and wider arithmetic in the CPU.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request; sampled only while idle (`busy`=0).
- `in_data1`  input  W  operand A; latched on the accepting edge.
- `in_data2`  input  W  operand B; latched on the accepting edge.
- `busy`  output  1  high while a computation is in progress.
- `done`  output  1  one-cycle pulse when the result becomes valid.
- `out_data`  output  W  result; holds its value between computations.
- `cy`  output  1  carry out of the most significant nibble.
- `sub`  input  1  present only with `SUB_EN`; selects A−B; latched with the operands.

## Operation
- FSM has two states:
  - IDLE → RUN when `start`=1 at a rising edge; operands are latched, nibble counter is cleared to 0, carry register is loaded with the initial carry.
  - RUN → IDLE on the edge that processes nibble NIBBLES−1.
- Per-nibble datapath:
  - Two `adder4` instances in series.
  - Stage 1 adds A[k] and B[k].
  - Stage 2 adds the stage-1 sum and {3'b0, carry_reg}.
  - Carry out of the nibble = cy1 | cy2. cy1 and cy2 are never both 1.
- Each RUN edge:
  - Writes the nibble sum into bits [4k+3:4k] of an internal result register.
  - Updates carry_reg with the nibble carry.
  - Increments the counter.
- `out_data` and `cy` load from the internal result and the final carry only on the RUN→IDLE edge. During RUN they keep the previous result.
- Arithmetic is modulo 2^W. No overflow flag; signed overflow is not reported.
- `start` while `busy`=1 is ignored. Operand changes during RUN have no effect.
- `start`=1 on the same cycle as `done` is accepted, because the FSM is already IDLE. Back-to-back operations are supported.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): `busy`=0, `done`=0, `out_data`=0, `cy`=0, FSM=IDLE, counter=0, carry_reg=0.
- Reset during RUN aborts the computation. No `done` is issued and all outputs read 0.
- Latency: start accepted at edge T0, then:
  - `busy`=1 from T0 through T0+NIBBLES−1.
  - Nibble k is processed at edge T0+1+k.
  - At edge T0+NIBBLES: `busy`=0, `done`=1, `out_data`/`cy` valid.
- Throughput: one result every NIBBLES cycles.
- `done` is high for exactly one cycle (T0+NIBBLES to T0+NIBBLES+1), regardless of `start`.
- The counter wraps to 0 on the RUN→IDLE edge and never exceeds NIBBLES−1.

## Configuration
- Macro `NIBBLE_SERIAL_ADDER_SUB_EN`.
- Defined:
  - Adds the `sub` port.
  - When `sub` is latched as 1, each B nibble is inverted before stage 1 and the initial carry_reg is 1, giving A + ~B + 1.
  - `cy`=1 means no borrow (A ≥ B unsigned).
- Undefined:
  - No `sub` port.
  - Initial carry is always 0.
  - The operation is addition only.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `out_data`=0x0000, `cy`=0, `busy`=0, `done`=0. Release, idle 3 cycles → no change.
- With NIBBLES=4: 0x1234 + 0x4321 → `out_data`=0x5555, `cy`=0. `done` is high exactly 4 cycles after the start edge, for 1 cycle. `busy` is high for 4 cycles.
- Carry ripple: 0x0FFF + 0x0001 → 0x1000, `cy`=0. 0xFFFF + 0xFFFF → 0xFFFE, `cy`=1. 0xFFFF + 0x0001 → 0x0000, `cy`=1.
- Handshake:
  - Start 0x0001+0x0001, re-assert `start` with 0x00FF+0x0001 during RUN → result 0x0002 only.
  - Assert `start` with 0x00FF+0x0001 on the `done` cycle → 0x0100 after 4 more cycles.
  - `out_data` stays 0x0002 during that run.
- Abort: start 0x7777+0x1111, pull `rst_n` low after 2 cycles → outputs 0 immediately, no `done`. After release, 0x0003+0x0004 → 0x0007.
- `NIBBLE_SERIAL_ADDER_SUB_EN` defined:
  - 0x0005 − 0x0007 → 0xFFFE, `cy`=0.
  - 0x1000 − 0x0001 → 0x0FFF, `cy`=1.
  - With `sub`=0 → add results identical to the earlier scenarios.
